pulse_event_arbiter: RTL and testbench

//   Multi-channel edge/pulse event detector and round-robin scheduler. Each

---
 rtl/pulse_event_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_pulse_event_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
// -----------------------------------------------------------------------------
// pulse_event_arbiter
//
// Purpose:
//   Multi-channel edge/pulse event detector feeding a round-robin scheduler.
//   Each channel watches one synchronous status bit with a selectable detector
//   (rising edge, falling edge or a one-cycle 0-1-0 pulse). Detected events are
//   latched as pending and handed out one at a time on a single valid/ready
//   event port shared by all channels.
//
// Ports:
//   clk          in   1        clock, all state updates on posedge
//   rst          in   1        synchronous reset, active-high
//   a            in   N_CH     channel inputs, already synchronous to clk
//   cfg_mode     in   2*N_CH   per-channel mode [2i+1:2i]:
//                              00 off, 01 rise, 10 pulse 010, 11 fall
//   ovf_clr      in   N_CH     per-channel pulse, clears sticky overflow
//   evt_valid    out  1        event offered (registered)
//   evt_ch       out  CH_W     channel index of the offered event (registered)
//   evt_ready    in   1        consumer accepts the offered event
//   pending      out  N_CH     per-channel pending-event flags (registered)
//   ovf          out  N_CH     per-channel sticky overflow flags (registered)
//   o_dbg_state  out  1        scheduler FSM state (0 idle, 1 offering)
//   o_dbg_ptr    out  CH_W     round-robin search start pointer
//
// Handshake:
//   evt_valid/evt_ch come straight from registers. Once evt_valid is high,
//   evt_valid and evt_ch stay constant until a cycle where evt_valid and
//   evt_ready are both high at the rising clock edge; that edge is the
//   transfer. The consumer may hold evt_ready high or low at will, and
//   evt_ready has no effect while evt_valid is low.
// -----------------------------------------------------------------------------
module pulse_event_arbiter #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   a,
    input  logic [2*N_CH-1:0] cfg_mode,
    input  logic [N_CH-1:0]   ovf_clr,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   ovf,
    output logic              o_dbg_state,
    output logic [CH_W-1:0]   o_dbg_ptr
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [N_CH-1:0]   r_a1;         // a delayed by one cycle
    logic [N_CH-1:0]   r_a2;         // a delayed by two cycles
    logic [N_CH-1:0]   r_pending;
    logic [N_CH-1:0]   r_ovf;
    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic [CH_W-1:0]   r_ptr;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [N_CH-1:0]   w_rise;
    logic [N_CH-1:0]   w_fall;
    logic [N_CH-1:0]   w_pulse;
    logic [N_CH-1:0]   w_det;
    logic              w_handshake;
    logic [CH_W-1:0]   w_ch_inc;
    logic [CH_W-1:0]   w_base;
    logic [CH_W:0]     w_search;
    logic              w_found;
    logic [CH_W-1:0]   w_winner;
    logic              w_load;
    logic [N_CH-1:0]   w_load_1h;
    logic [N_CH-1:0]   w_ovf_set;
    logic [N_CH-1:0]   w_pending_nxt;
    logic [N_CH-1:0]   w_ovf_nxt;
    state_t            w_state_nxt;
    logic              w_valid_nxt;
    logic [CH_W-1:0]   w_ch_nxt;
    logic [CH_W-1:0]   w_ptr_nxt;

    // (base + k) mod N_CH for 0 <= k < N_CH; works for non power-of-two N_CH.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_CH) begin
            s = s - N_CH;
        end
        return CH_W'(s);
    endfunction

    // Returns {found, index} of the first set request scanning upward from
    // base with wrap-around.
    function automatic logic [CH_W:0] find_winner(input logic [N_CH-1:0] req,
                                                  input logic [CH_W-1:0] base);
        logic [CH_W:0]   res;
        logic [CH_W-1:0] idx;
        res = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = wrap_add(base, k);
            if (!res[CH_W] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Event detection, evaluated on the current input against its history
    // -------------------------------------------------------------------------
    assign w_rise  = ~r_a1 & a;
    assign w_fall  =  r_a1 & ~a;
    assign w_pulse = ~r_a2 & r_a1 & ~a;

    always_comb begin
        w_det = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (cfg_mode[2*i +: 2])
                2'b01:   w_det[i] = w_rise[i];
                2'b10:   w_det[i] = w_pulse[i];
                2'b11:   w_det[i] = w_fall[i];
                default: w_det[i] = 1'b0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
    assign w_handshake = r_evt_valid & evt_ready;

    // Channel after the one currently offered, modulo N_CH.
    assign w_ch_inc = (r_evt_ch == CH_W'(N_CH - 1)) ? '0 : r_evt_ch + CH_W'(1);

    // In OFFER a new winner is only loaded on a handshake, and then the
    // pointer is about to become evt_ch+1, so search from there directly.
    assign w_base   = (r_state == ST_OFFER) ? w_ch_inc : r_ptr;
    assign w_search = find_winner(r_pending, w_base);
    assign w_found  = w_search[CH_W];
    assign w_winner = w_search[CH_W-1:0];

    // -------------------------------------------------------------------------
    // Scheduler FSM: next state and output register updates
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_valid_nxt = r_evt_valid;
        w_ch_nxt    = r_evt_ch;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_ch_nxt    = w_winner;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (w_handshake) begin
                    w_ptr_nxt = w_ch_inc;
                    if (w_found) begin
                        // Back-to-back: next event replaces the accepted one.
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_ch_nxt    = w_winner;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pending and overflow bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        w_load_1h = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_load_1h[i] = w_load && (w_winner == CH_W'(i));
        end
    end

    // A channel whose pending event moves into the output register this
    // cycle has room for a new detection, so only a detection that meets an
    // occupied, non-departing pending slot counts as overflow.
    assign w_ovf_set     = w_det & r_pending & ~w_load_1h;
    assign w_pending_nxt = (r_pending & ~w_load_1h) | w_det;
    // Set has priority over clear.
    assign w_ovf_nxt     = (r_ovf & ~ovf_clr) | w_ovf_set;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a1        <= '0;
            r_a2        <= '0;
            r_pending   <= '0;
            r_ovf       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_a1        <= a;
            r_a2        <= r_a1;
            r_pending   <= w_pending_nxt;
            r_ovf       <= w_ovf_nxt;
            r_evt_valid <= w_valid_nxt;
            r_evt_ch    <= w_ch_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign evt_valid   = r_evt_valid;
    assign evt_ch      = r_evt_ch;
    assign pending     = r_pending;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pulse_event_arbiter
//
// Bench for pulse_event_arbiter with N_CH = 4. A table of per-cycle records
// holds the inputs applied during one cycle and the registered outputs
// expected right after that cycle's rising edge. Hand-written sequences
// afterwards cover mode changes with events already pending and draining the
// port through an expected-channel queue.
// -----------------------------------------------------------------------------
module tb_pulse_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   a;
    logic [2*N_CH-1:0] cfg_mode;
    logic [N_CH-1:0]   ovf_clr;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_ready;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   ovf;
    logic              dbg_state;
    logic [CH_W-1:0]   dbg_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pulse_event_arbiter #(.N_CH(N_CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .cfg_mode    (cfg_mode),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_ch      (evt_ch),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .ovf         (ovf),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [CH_W-1:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [7:0] mode;
        logic [3:0] clr;
        logic       rdy;
        logic       ev;
        logic [1:0] ech;
        logic [3:0] epend;
        logic [3:0] eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] av, input logic [7:0] m,
                       input logic [3:0] c, input logic rd, input logic ev,
                       input logic [1:0] ech, input logic [3:0] ep,
                       input logic [3:0] eo);
        vec_t v;
        v.rst = r;  v.a = av;   v.mode = m;    v.clr = c;  v.rdy = rd;
        v.ev  = ev; v.ech = ech; v.epend = ep; v.eovf = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver: inputs change on the falling edge, outputs sampled 1 after the
    // following rising edge.
    // -------------------------------------------------------------------------
    task automatic drive(input logic r, input logic [3:0] av, input logic [7:0] m,
                         input logic [3:0] c, input logic rd);
        @(negedge clk);
        rst       = r;
        a         = av;
        cfg_mode  = m;
        ovf_clr   = c;
        evt_ready = rd;
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Safety timeout
    // -------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1; a = '0; cfg_mode = '0; ovf_clr = '0; evt_ready = 1'b0;

        //   rst a        mode   clr      rdy  ev  ch  pend     ovf
        // Rising edge on ch0, latency and single event.
        add(1, 4'b0000, 8'h00, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 0
        add(0, 4'b0000, 8'h01, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 1
        add(0, 4'b0001, 8'h01, 4'b0000, 1,   0,  0,  4'b0001, 4'b0000); // 2 det
        add(0, 4'b0001, 8'h01, 4'b0000, 1,   1,  0,  4'b0000, 4'b0000); // 3 offer
        add(0, 4'b0001, 8'h01, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 4
        add(0, 4'b0001, 8'h01, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 5
        add(0, 4'b0000, 8'h01, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 6
        // ch1 pulse 010 -> one event; 0110 -> none; ch2 fall -> one event.
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 7
        add(0, 4'b0010, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 8
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0010, 4'b0000); // 9
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   1,  1,  4'b0000, 4'b0000); // 10
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 11
        add(0, 4'b0010, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 12
        add(0, 4'b0010, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 13
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 14
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 15
        add(0, 4'b0100, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 16
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0100, 4'b0000); // 17
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   1,  2,  4'b0000, 4'b0000); // 18
        add(0, 4'b0000, 8'h38, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 19
        // All channels rise together -> 0,1,2,3 back-to-back; then 1,3.
        add(1, 4'b0000, 8'h55, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 20
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   0,  0,  4'b1111, 4'b0000); // 21
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  0,  4'b1110, 4'b0000); // 22
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  1,  4'b1100, 4'b0000); // 23
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  2,  4'b1000, 4'b0000); // 24
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  3,  4'b0000, 4'b0000); // 25
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 26
        add(0, 4'b0101, 8'h55, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 27
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   0,  0,  4'b1010, 4'b0000); // 28
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  1,  4'b1000, 4'b0000); // 29
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  3,  4'b0000, 4'b0000); // 30
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   0,  0,  4'b0000, 4'b0000); // 31
        // Stalled consumer, three rises on ch2: offered + pending + overflow.
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   0,  0,  4'b0000, 4'b0000); // 32
        add(0, 4'b0100, 8'h10, 4'b0000, 0,   0,  0,  4'b0100, 4'b0000); // 33
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   1,  2,  4'b0000, 4'b0000); // 34
        add(0, 4'b0100, 8'h10, 4'b0000, 0,   1,  2,  4'b0100, 4'b0000); // 35
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   1,  2,  4'b0100, 4'b0000); // 36
        add(0, 4'b0100, 8'h10, 4'b0000, 0,   1,  2,  4'b0100, 4'b0100); // 37
        add(0, 4'b0100, 8'h10, 4'b0000, 1,   1,  2,  4'b0000, 4'b0100); // 38
        add(0, 4'b0100, 8'h10, 4'b0000, 1,   0,  0,  4'b0000, 4'b0100); // 39
        // Overflow set and clear in the same cycle, then clear alone.
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   0,  0,  4'b0000, 4'b0100); // 40
        add(0, 4'b0100, 8'h10, 4'b0000, 0,   0,  0,  4'b0100, 4'b0100); // 41
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   1,  2,  4'b0000, 4'b0100); // 42
        add(0, 4'b0100, 8'h10, 4'b0000, 0,   1,  2,  4'b0100, 4'b0100); // 43
        add(0, 4'b0000, 8'h10, 4'b0000, 0,   1,  2,  4'b0100, 4'b0100); // 44
        add(0, 4'b0100, 8'h10, 4'b0100, 0,   1,  2,  4'b0100, 4'b0100); // 45
        add(0, 4'b0000, 8'h10, 4'b0100, 0,   1,  2,  4'b0100, 4'b0000); // 46
        // Reset during OFFER with pending 1010 and ovf set.
        add(0, 4'b0000, 8'h10, 4'b0000, 1,   1,  2,  4'b0000, 4'b0000); // 47
        add(0, 4'b1010, 8'h55, 4'b0000, 0,   1,  2,  4'b1010, 4'b0000); // 48
        add(0, 4'b0000, 8'h55, 4'b0000, 0,   1,  2,  4'b1010, 4'b0000); // 49
        add(0, 4'b0010, 8'h55, 4'b0000, 0,   1,  2,  4'b1010, 4'b0010); // 50
        add(1, 4'b0010, 8'h55, 4'b0000, 0,   0,  0,  4'b0000, 4'b0000); // 51
        add(0, 4'b0000, 8'h55, 4'b0000, 0,   0,  0,  4'b0000, 4'b0000); // 52
        add(0, 4'b1111, 8'h55, 4'b0000, 0,   0,  0,  4'b1111, 4'b0000); // 53
        add(0, 4'b1111, 8'h55, 4'b0000, 0,   1,  0,  4'b1110, 4'b0000); // 54
        add(0, 4'b1111, 8'h55, 4'b0000, 1,   1,  1,  4'b1100, 4'b0000); // 55

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].a, vecs[i].mode, vecs[i].clr, vecs[i].rdy);
            check("evt_valid", i, 8'(evt_valid), 8'(vecs[i].ev));
            if (vecs[i].ev) begin
                check("evt_ch", i, 8'(evt_ch), 8'(vecs[i].ech));
            end
            check("pending", i, 8'(pending), 8'(vecs[i].epend));
            check("ovf", i, 8'(ovf), 8'(vecs[i].eovf));
        end

        // ---------------------------------------------------------------------
        // Mode switched off while an event is pending: the event is still
        // delivered, and no new detection happens in mode 00.
        // ---------------------------------------------------------------------
        drive(1, 4'b0000, 8'h00, 4'b0000, 0);
        check("seq_rst_valid", 0, 8'(evt_valid), 8'h00);
        check("seq_rst_state", 0, 8'(dbg_state), 8'h00);
        check("seq_rst_ptr", 0, 8'(dbg_ptr), 8'h00);

        drive(0, 4'b0001, 8'h01, 4'b0000, 0);
        exp_q.push_back(2'd0);
        check("seq_det_pending", 1, 8'(pending), 8'h01);
        check("seq_det_valid", 1, 8'(evt_valid), 8'h00);

        drive(0, 4'b0000, 8'h00, 4'b0000, 0);
        check("seq_load_valid", 2, 8'(evt_valid), 8'h01);
        check("seq_load_ch", 2, 8'(evt_ch), 8'h00);
        check("seq_load_pending", 2, 8'(pending), 8'h00);
        check("seq_load_state", 2, 8'(dbg_state), 8'h01);

        drive(0, 4'b0001, 8'h00, 4'b0000, 0);
        check("seq_off_pending", 3, 8'(pending), 8'h00);
        check("seq_hold_valid", 3, 8'(evt_valid), 8'h01);

        drive(0, 4'b0000, 8'h00, 4'b0000, 0);
        check("seq_off_pending", 4, 8'(pending), 8'h00);
        check("seq_hold_ch", 4, 8'(evt_ch), 8'h00);

        // Drain with a bounded cycle budget, matching each accepted event
        // against the expected-channel queue.
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            a         = '0;
            evt_ready = 1'b1;
            if (evt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_evt", cyc, 8'(evt_ch), 8'hff);
                end else begin
                    check("drain_ch", cyc, 8'(evt_ch), 8'(exp_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
            if (evt_valid === 1'b0 && exp_q.size() == 0) begin
                break;
            end
        end
        check("drain_queue_empty", 0, 8'(exp_q.size()), 8'h00);
        check("drain_valid_low", 0, 8'(evt_valid), 8'h00);
        check("drain_ptr", 0, 8'(dbg_ptr), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
